// File: rtl/address_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : address_sequencer
// Brief    : Bounded, triggerable word-address sweep controller for a BRAM port.
//            Define ADDR_SEQ_CONTINUOUS_EN to add the `continuous` re-arm input.
// Revision : 1.0 - initial release
// ============================================================================
module address_sequencer #(
    parameter int COUNT_WIDTH  = 13,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    trig_en,
    input  logic                    trigger,
`ifdef ADDR_SEQ_CONTINUOUS_EN
    input  logic                    continuous,
`endif
    input  logic [COUNT_WIDTH-1:0]  count_max,
    input  logic [PERIOD_WIDTH-1:0] n_periods,
    output logic [COUNT_WIDTH+1:0]  address,
    output logic                    wen,
    output logic                    first,
    output logic                    last,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0]  c_one_cnt = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_WIDTH-1:0] c_one_per = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic [COUNT_WIDTH-1:0]  cm_q, cm_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [PERIOD_WIDTH-1:0] np_q, np_d;
    logic                    wen_q, wen_d;
    logic                    first_q, first_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    w_continuous;
    logic [PERIOD_WIDTH-1:0] w_np_new;

`ifdef ADDR_SEQ_CONTINUOUS_EN
    assign w_continuous = continuous;
`else
    assign w_continuous = 1'b0;
`endif

    assign w_np_new = (n_periods == '0) ? c_one_per : n_periods;

    // count_d/period_d always name the word presented after the coming edge,
    // so the registered markers are derived from the next-state values.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        cm_d     = cm_q;
        np_d     = np_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cm_d     = count_max;
                    np_d     = w_np_new;
                    count_d  = '0;
                    period_d = '0;
                    if (trig_en) state_d = S_ARMED;
                    else         state_d = S_RUN;
                end
            end
            S_ARMED: begin
                if (trigger) state_d = S_RUN;
            end
            S_RUN: begin
                if (count_q == cm_q) begin
                    count_d = '0;
                    if (period_q == np_q - c_one_per) begin
                        period_d = '0;
                        done_d   = 1'b1;
                        if (w_continuous) begin
                            cm_d = count_max;
                            np_d = w_np_new;
                            if (trig_en) state_d = S_ARMED;
                            else         state_d = S_RUN;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        period_d = period_q + c_one_per;
                    end
                end else begin
                    count_d = count_q + c_one_cnt;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d  = S_IDLE;
            count_d  = '0;
            period_d = '0;
            done_d   = 1'b0;
        end

        wen_d   = (state_d == S_RUN);
        busy_d  = (state_d != S_IDLE);
        first_d = wen_d && (count_d == '0) && (period_d == '0);
        last_d  = wen_d && (count_d == cm_d) && (period_d == np_d - c_one_per);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            period_q <= '0;
            cm_q     <= '0;
            np_q     <= '0;
            wen_q    <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            cm_q     <= cm_d;
            np_q     <= np_d;
            wen_q    <= wen_d;
            first_q  <= first_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign address = {count_q, 2'b00};
    assign period  = period_q;
    assign wen     = wen_q;
    assign first   = first_q;
    assign last    = last_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_address_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_address_sequencer
// Brief    : Scoreboard bench for address_sequencer with directed sweeps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_address_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0, abort = 1'b0, trig_en = 1'b0, trigger = 1'b0;
    logic [12:0] count_max = '0;
    logic [15:0] n_periods = '0;
    logic [14:0] address;
    logic        wen, first, last, busy, done;
    logic [15:0] period;
`ifdef ADDR_SEQ_CONTINUOUS_EN
    logic        continuous = 1'b0;
`endif

    typedef struct packed {
        logic [14:0] addr;
        logic        wen, first, last, busy, done;
        logic [15:0] period;
    } rec_t;

    rec_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    address_sequencer #(.COUNT_WIDTH(13), .PERIOD_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .trig_en(trig_en), .trigger(trigger),
`ifdef ADDR_SEQ_CONTINUOUS_EN
        .continuous(continuous),
`endif
        .count_max(count_max), .n_periods(n_periods), .address(address),
        .wen(wen), .first(first), .last(last), .period(period),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t word(input int c, input int p, input bit f, input bit l, input bit d);
        rec_t r;
        r.addr = 15'(c * 4); r.wen = 1'b1; r.first = f; r.last = l;
        r.busy = 1'b1; r.done = d; r.period = 16'(p);
        return r;
    endfunction

    function automatic rec_t done_rec();
        rec_t r;
        r = '0;
        r.done = 1'b1;
        return r;
    endfunction

    // Expected words of a non-continuous sweep plus the trailing done cycle.
    task automatic push_sweep(input int cm, input int np);
        for (int p = 0; p < np; p++)
            for (int c = 0; c <= cm; c++)
                q.push_back(word(c, p, (c == 0 && p == 0), (c == cm && p == np - 1), 1'b0));
        q.push_back(done_rec());
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && q.size() != 0; i++) tick();
        chk({name, "_drained"}, q.size(), 0);
        q.delete();
    endtask

    always @(negedge clk) begin
        rec_t a, e;
        if (resetn && (wen || done)) begin
            a = {address, wen, first, last, busy, done, period};
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output: got %h expected none", a);
            end else begin
                e = q.pop_front();
                if (!e.wen) a.period = e.period;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard: got addr=%0h wen=%b f=%b l=%b busy=%b done=%b per=%0d expected addr=%0h wen=%b f=%b l=%b busy=%b done=%b per=%0d",
                             a.addr, a.wen, a.first, a.last, a.busy, a.done, a.period,
                             e.addr, e.wen, e.first, e.last, e.busy, e.done, e.period);
                end
            end
        end
    end

    initial begin
        repeat (2) tick();
        chk("rst_address", 32'(address), 0);
        chk("rst_wen", 32'(wen), 0);
        chk("rst_first", 32'(first), 0);
        chk("rst_last", 32'(last), 0);
        chk("rst_period", 32'(period), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        resetn = 1'b1;
        tick();

        // Basic sweep; configuration changes after the latch must be ignored.
        count_max = 13'd3; n_periods = 16'd2; start = 1'b1;
        push_sweep(3, 2);
        tick();
        start = 1'b0; count_max = 13'd9; n_periods = 16'd5;
        chk("sweep_first_busy", 32'(busy), 1);
        drain("sweep");
        chk("sweep_idle_busy", 32'(busy), 0);

        // Triggered sweep: ARMED for 10 cycles with wen low.
        trig_en = 1'b1; count_max = 13'd1; n_periods = 16'd1; start = 1'b1;
        push_sweep(1, 1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("armed_busy", 32'(busy), 1);
            chk("armed_wen", 32'(wen), 0);
            tick();
        end
        trigger = 1'b1;
        tick();
        trigger = 1'b0; trig_en = 1'b0;
        chk("trig_first_wen", 32'(wen), 1);
        chk("trig_first_marker", 32'(first), 1);
        drain("trig");

        // Single-word sweep with n_periods=0 treated as 1.
        count_max = 13'd0; n_periods = 16'd0; start = 1'b1;
        push_sweep(0, 1);
        tick();
        start = 1'b0;
        drain("single");

        // Abort on the 5th RUN cycle with start also high.
        count_max = 13'd7; n_periods = 16'd1; start = 1'b1;
        for (int c = 0; c < 5; c++) q.push_back(word(c, 0, c == 0, 1'b0, 1'b0));
        tick();
        start = 1'b0;
        repeat (4) tick();
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_wen", 32'(wen), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_address", 32'(address), 0);
        tick();
        chk("abort_start_ignored", 32'(busy), 0);
        chk("abort_queue_empty", q.size(), 0);
        count_max = 13'd1; start = 1'b1;
        push_sweep(1, 1);
        tick();
        start = 1'b0;
        drain("restart");

        // Asynchronous reset in the middle of a sweep.
        count_max = 13'd7; n_periods = 16'd1; start = 1'b1;
        push_sweep(7, 1);
        tick();
        start = 1'b0;
        repeat (2) tick();
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_wen", 32'(wen), 0);
        chk("mid_rst_address", 32'(address), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_first_last", 32'({first, last}), 0);
        chk("mid_rst_period", 32'(period), 0);
        q.delete();
        tick();
        resetn = 1'b1;
        repeat (2) tick();
        chk("post_rst_idle", 32'(busy), 0);

`ifdef ADDR_SEQ_CONTINUOUS_EN
        continuous = 1'b1; count_max = 13'd1; n_periods = 16'd1; start = 1'b1;
        q.push_back(word(0, 0, 1'b1, 1'b0, 1'b0));
        q.push_back(word(1, 0, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < 2; k++) begin
            q.push_back(word(0, 0, 1'b1, 1'b0, 1'b1));
            q.push_back(word(1, 0, 1'b0, 1'b1, 1'b0));
        end
        q.push_back(done_rec());
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("cont_busy", 32'(busy), 1);
        continuous = 1'b0;
        drain("continuous");
        chk("cont_end_busy", 32'(busy), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/address_sequencer.md
# address_sequencer

Controller that sequences a word-aligned BRAM address counter for acquisition and playback paths. It accepts a start request, optionally waits for a trigger, and sweeps addresses 0..count_max for a programmed number of periods. It drives the write enable, first/last markers and busy/done status seen by the AXI-side registers. It sits between the configuration register file and the BRAM port, in place of a free-running address generator wherever a bounded, triggerable sweep is required.

## Interface
- COUNT_WIDTH, 13, width of the word counter; address is COUNT_WIDTH+2 bits (byte address, 4-byte words)
- PERIOD_WIDTH, 16, width of the period counter
- clk  in  1  clock, all logic rising-edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  start request, sampled per cycle
- abort  in  1  stop immediately, no done pulse
- trig_en  in  1  wait for trigger before sweeping
- trigger  in  1  trigger level, sampled in ARMED
- count_max  in  COUNT_WIDTH  last word index per period
- n_periods  in  PERIOD_WIDTH  number of periods; 0 treated as 1
- address  out  COUNT_WIDTH+2  {count, 2'b00}
- wen  out  1  BRAM write enable, high for every RUN cycle
- first  out  1  high with word 0 of period 0
- last  out  1  high with word count_max of final period
- period  out  PERIOD_WIDTH  current period index
- busy  out  1  high in ARMED and RUN
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ARMED, RUN. All outputs registered.
- IDLE: start=1 latches count_max→cm_reg, max(n_periods,1)→np_reg, clears count and period; next state ARMED if trig_en=1 else RUN.
- ARMED: trigger=1 → RUN next cycle; otherwise wait indefinitely.
- RUN: each cycle wen=1, address={count,2'b00}. count==cm_reg: count→0, period+1; if period==np_reg-1 exit to IDLE and assert done next cycle.
- count_max/n_periods changes are ignored until the next latch.
- cm_reg=0: each period is a single word; first and last both high when np_reg=1.
- start while busy is ignored. abort in any state: IDLE next cycle, wen=0, done=0, count/period cleared. abort wins over start in the same cycle.
- Arithmetic is unsigned, with no wrap beyond cm_reg. period never exceeds np_reg-1.

## Timing
- Reset values: address=0, wen=0, first=0, last=0, period=0, busy=0, done=0, state IDLE.
- start sampled at edge t with trig_en=0: busy=1, wen=1, address=0, first=1 from edge t+1.
- trig_en=1: busy=1 from edge t+1. trigger sampled at edge u: first wen cycle from edge u+1.
- RUN length is exactly (cm_reg+1)·np_reg cycles.
- done=1 and busy=0 for the single cycle after the last wen cycle.
- A start asserted during the done cycle is accepted, giving back-to-back sweeps with one idle cycle.

## Configuration
- ADDR_SEQ_CONTINUOUS_EN defined: adds input `continuous` (1 bit).
  - If continuous=1 at the final word, the block re-latches count_max/n_periods, pulses done, and keeps busy=1.
  - It then goes to ARMED (trig_en=1) or directly to RUN with address 0 on the next cycle (trig_en=0).
  - abort still stops it.
- Not defined: the port is absent and behaviour is identical to continuous=0.

## Test plan
- Reset mid-RUN (resetn low asynchronously): all outputs 0 immediately; IDLE after release.
- count_max=3, n_periods=2, trig_en=0, start pulse: 8 wen cycles, addresses 0,4,8,12,0,4,8,12. first on cycle 1, last on cycle 8, period 0 then 1. done one cycle later.
- trig_en=1, trigger held low 10 cycles, then high: busy=1 with wen=0 for 10 cycles; first wen cycle follows the trigger edge by one.
- count_max=0, n_periods=0: exactly one wen cycle at address 0 with first=last=1, then done.
- abort at the 5th RUN cycle with start also high: wen drops next cycle, no done, start ignored. A fresh start restarts at address 0.
- ADDR_SEQ_CONTINUOUS_EN, continuous=1, count_max=1, n_periods=1: addresses 0,4,0,4…, done pulses every 2 cycles, busy stays 1. Clearing continuous ends the sweep after the current period.
